enc_3_sigmoid: RTL and testbench
================================

Name: enc_3_sigmoid

Overview:
Downstream activation stage for the enc_3 dense layer. Accepts the 6-element fixed-point vector y = w*x + b through a valid/ready handshake. Applies a shift-only piecewise-linear sigmoid to one element per cycle using a single shared datapath, then presents the activated vector to the next encoder stage and holds it until that stage accepts it.

Parameters:
BITSIZE, 16, element width; signed two's complement, Q8.8.
N, 6, vector length (elements per transfer).
FRAC, 8, fractional bits; breakpoint and offset constants are scaled by 2^FRAC.

Ports:
clk  input  1  rising-edge clock.
reset  input  1  asynchronous, active-low reset (0 = reset asserted).
in_valid  input  1  upstream vector on x is valid.
in_ready  output  1  block can accept a vector; high only in IDLE.
x  input  BITSIZE*N  input vector; element i at [BITSIZE*i +: BITSIZE].
out_valid  output  1  y holds a complete activated vector.
out_ready  input  1  downstream accepts y.
y  output  BITSIZE*N  activated vector; element i at [BITSIZE*i +: BITSIZE].

Behaviour:
- Reset (reset==0, async): state=IDLE, idx=0, x_reg=0, y=0, out_valid=0; in_ready=1 (it is decoded from IDLE).
- A reset during RUN or HOLD aborts the operation and discards the captured vector. No partial y is presented.
- FSM IDLE: in_ready=1. On in_valid & in_ready at a rising edge, capture x into x_reg, set idx=0, go to RUN. While in IDLE, changes on x do not affect y.
- FSM RUN: in_ready=0, out_valid=0. Each edge writes y[idx] = f(x_reg[idx]) and increments idx.
- RUN to HOLD: after the edge that writes idx=N-1, go to HOLD and set out_valid=1.
- Latency: out_valid rises exactly N cycles after the accept edge (6 cycles at default).
- FSM HOLD: out_valid=1 and y stays stable. On out_valid & out_ready, clear out_valid and go to IDLE; in_ready is high the next cycle.
- No overlap between vectors: back-to-back throughput is one vector per N+2 cycles when both sides are always ready. in_valid seen during RUN or HOLD is ignored (in_ready=0).
- out_ready asserted before out_valid has no effect. out_ready held high lets HOLD last exactly one cycle.
- Activation f(v), computed on a=|v|:
  - a = -v for v<0, saturated: v=-32768 gives a=32767.
  - a>=5.0 (1280): g=1.0 (256).
  - 2.375 (608)<=a<5.0: g=(a>>>5)+216 (0.84375).
  - 1.0 (256)<=a<2.375: g=(a>>>3)+160 (0.625).
  - 0<=a<1.0: g=(a>>>2)+128 (0.5).
  - f=g for v>=0; f=256-g for v<0.
- All shifts act on non-negative a, so logical and arithmetic shifts give the same result. Result range is 0..256, so no overflow is possible.
- Comparisons are signed against Q8.8 constants; breakpoint equality takes the upper segment.

Decomposition:
- Shared package (enc_pkg):
  - Q8.8 constants ONE=256, HALF=128, BP1=256, BP2=608, BP3=1280, OFF2=160, OFF3=216.
  - Shift amounts 2/3/5.
  - FSM state encoding IDLE/RUN/HOLD.
  - Reuse these constants in the other encoder/decoder activation stages.
- One combinational sub-module, sigmoid_pwl (BITSIZE in, BITSIZE out), instanced once and fed by x_reg[idx].
- The top level holds the FSM, the idx counter, the x_reg/y registers and the handshake.

Test Plan:
- After reset release, drive x={0, 256, -256, 512, 768, 1280} with in_valid pulsed for one cycle. Require out_valid exactly 6 cycles after the accept edge and y={128, 192, 64, 224, 240, 256}.
- Drive x={-32768, 32767, 128, -128, 608, 607}. Require y={0, 256, 160, 96, 235, 235}; this covers saturation and the 2.375 breakpoint.
- Hold out_ready=0 for 10 cycles in HOLD while toggling x and in_valid. Require y stable, in_ready=0 and out_valid=1. Raise out_ready: out_valid drops next edge and in_ready=1.
- Hold in_valid=1 and out_ready=1 continuously over 3 distinct vectors. Require exactly 3 out_valid pulses, each one cycle wide, spaced N+2=8 cycles apart, with correct y for each vector.
- Assert reset=0 at idx=3 during RUN, then release. Require immediate out_valid=0, y=0, in_ready=1. The next vector x=all 256 yields y=all 192 with no stale elements.
- Drive in_valid=0 with out_ready=1 for 20 cycles from IDLE. Require out_valid never asserts and y stays 0.

Source files
------------

// File: rtl/enc_pkg.sv
// Shared Q8.8 constants and FSM encoding for the encoder/decoder activation stages.
package enc_pkg;

  localparam int FRAC = 8;

  // Breakpoints and offsets expressed as exact binary fractions of 2^FRAC
  localparam int ONE  = 1 << FRAC;          // 1.0     = 256
  localparam int HALF = 1 << (FRAC - 1);    // 0.5     = 128
  localparam int BP1  = ONE;                // 1.0     = 256
  localparam int BP2  = 19 << (FRAC - 3);   // 2.375   = 608
  localparam int BP3  = 5 << FRAC;          // 5.0     = 1280
  localparam int OFF2 = 5 << (FRAC - 3);    // 0.625   = 160
  localparam int OFF3 = 27 << (FRAC - 5);   // 0.84375 = 216

  localparam int SH1 = 2;
  localparam int SH2 = 3;
  localparam int SH3 = 5;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    HOLD = 2'd2
  } state_e;

endpackage

// File: rtl/sigmoid_pwl.sv
// Shift-only piecewise-linear sigmoid on one signed Q8.8 element; purely combinational.
module sigmoid_pwl
  import enc_pkg::*;
#(
  parameter int unsigned BITSIZE = 16
) (
  input  logic signed [BITSIZE-1:0] v_i,
  output logic signed [BITSIZE-1:0] f_c
);

  localparam logic signed [BITSIZE-1:0] S_MIN = {1'b1, {(BITSIZE-1){1'b0}}};
  localparam logic signed [BITSIZE-1:0] S_MAX = {1'b0, {(BITSIZE-1){1'b1}}};

  logic signed [BITSIZE-1:0] a;
  logic signed [BITSIZE-1:0] g;

  // Fold to |v| (saturating the most negative code), evaluate g, then mirror around 0.5
  always_comb begin
    a = v_i;
    if (v_i < 0) begin
      a = (v_i == S_MIN) ? S_MAX : -v_i;
    end

    if (a >= BITSIZE'(BP3)) begin
      g = BITSIZE'(ONE);
    end else if (a >= BITSIZE'(BP2)) begin
      g = (a >>> SH3) + BITSIZE'(OFF3);
    end else if (a >= BITSIZE'(BP1)) begin
      g = (a >>> SH2) + BITSIZE'(OFF2);
    end else begin
      g = (a >>> SH1) + BITSIZE'(HALF);
    end

    f_c = (v_i < 0) ? (BITSIZE'(ONE) - g) : g;
  end

endmodule

// File: rtl/enc_3_sigmoid.sv
// enc_3 activation stage: captures a vector, activates one element per cycle, holds result until taken.
module enc_3_sigmoid
  import enc_pkg::*;
#(
  parameter int unsigned BITSIZE = 16,
  parameter int unsigned N       = 6
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [BITSIZE*N-1:0] x,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [BITSIZE*N-1:0] y
);

  localparam int unsigned IDX_W = $clog2(N);
  localparam logic [IDX_W-1:0] LAST = IDX_W'(N - 1);

  state_e               state_q;
  logic [IDX_W-1:0]     idx_q;
  logic [BITSIZE*N-1:0] x_q;
  logic [BITSIZE*N-1:0] y_q;
  logic                 out_valid_q;
  logic                 in_ready_q;

  logic signed [BITSIZE-1:0] elem;
  logic signed [BITSIZE-1:0] act;

  assign elem = x_q[BITSIZE*idx_q +: BITSIZE];

  sigmoid_pwl #(.BITSIZE(BITSIZE)) u_pwl (
    .v_i (elem),
    .f_c (act)
  );

  // Control FSM; in_ready tracks IDLE and is updated alongside the state
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q     <= IDLE;
      idx_q       <= '0;
      x_q         <= '0;
      y_q         <= '0;
      out_valid_q <= 1'b0;
      in_ready_q  <= 1'b1;
    end else begin
      case (state_q)
        IDLE: begin
          if (in_valid) begin
            x_q        <= x;
            idx_q      <= '0;
            in_ready_q <= 1'b0;
            state_q    <= RUN;
          end
        end
        RUN: begin
          y_q[BITSIZE*idx_q +: BITSIZE] <= act;
          if (idx_q == LAST) begin
            idx_q       <= '0;
            out_valid_q <= 1'b1;
            state_q     <= HOLD;
          end else begin
            idx_q <= idx_q + IDX_W'(1);
          end
        end
        HOLD: begin
          if (out_ready) begin
            out_valid_q <= 1'b0;
            in_ready_q  <= 1'b1;
            state_q     <= IDLE;
          end
        end
        default: begin
          out_valid_q <= 1'b0;
          in_ready_q  <= 1'b1;
          state_q     <= IDLE;
        end
      endcase
    end
  end

  assign in_ready  = in_ready_q;
  assign out_valid = out_valid_q;
  assign y         = y_q;

endmodule

// File: tb/tb_enc_3_sigmoid.sv
// Directed self-checking bench for enc_3_sigmoid.
module tb_enc_3_sigmoid;

  logic        clk;
  logic        reset;
  logic        in_valid;
  logic        in_ready;
  logic [95:0] x;
  logic        out_valid;
  logic        out_ready;
  logic [95:0] y;

  int checks;
  int passed;

  enc_3_sigmoid #(.BITSIZE(16), .N(6)) dut (
    .clk       (clk),
    .reset     (reset),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .x         (x),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .y         (y)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [95:0] pack6(input int e0, input int e1, input int e2,
                                        input int e3, input int e4, input int e5);
    pack6 = {16'(e5), 16'(e4), 16'(e3), 16'(e2), 16'(e1), 16'(e0)};
  endfunction

  // Present x for one cycle at a negedge; returns after the accept edge
  task automatic send(input logic [95:0] v);
    x        = v;
    in_valid = 1'b1;
    @(negedge clk);
    in_valid = 1'b0;
  endtask

  // Count negedges from just after the accept edge until out_valid, bounded
  task automatic wait_ov(output int k);
    k = 0;
    while (!out_valid && k < 30) begin
      @(negedge clk);
      k++;
    end
  endtask

  task automatic test_reset;
    checks++; if (in_ready !== 1'b1) $display("FAIL reset_in_ready got %0b want 1", in_ready); else passed++;
    checks++; if (out_valid !== 1'b0) $display("FAIL reset_out_valid got %0b want 0", out_valid); else passed++;
    checks++; if (y !== 96'd0) $display("FAIL reset_y got %h want 0", y); else passed++;
    reset = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_idle_quiet;
    int ov_seen;
    int y_bad;
    ov_seen = 0;
    y_bad   = 0;
    in_valid  = 1'b0;
    out_ready = 1'b1;
    for (int i = 0; i < 20; i++) begin
      x = {$urandom(), $urandom(), $urandom()};
      @(negedge clk);
      if (out_valid !== 1'b0) ov_seen++;
      if (y !== 96'd0) y_bad++;
    end
    out_ready = 1'b0;
    checks++; if (ov_seen != 0) $display("FAIL idle_out_valid got %0d high cycles want 0", ov_seen); else passed++;
    checks++; if (y_bad != 0) $display("FAIL idle_y got %0d nonzero cycles want 0", y_bad); else passed++;
  endtask

  task automatic test_basic;
    int k;
    checks++; if (in_ready !== 1'b1) $display("FAIL basic_in_ready got %0b want 1", in_ready); else passed++;
    send(pack6(0, 256, -256, 512, 768, 1280));
    wait_ov(k);
    checks++; if (k != 6) $display("FAIL basic_latency got %0d want 6", k); else passed++;
    checks++; if (y !== pack6(128, 192, 64, 224, 240, 256))
      $display("FAIL basic_y got %h want %h", y, pack6(128, 192, 64, 224, 240, 256)); else passed++;
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
    checks++; if (out_valid !== 1'b0) $display("FAIL basic_release_ov got %0b want 0", out_valid); else passed++;
    checks++; if (in_ready !== 1'b1) $display("FAIL basic_release_ir got %0b want 1", in_ready); else passed++;
  endtask

  task automatic test_saturation;
    int k;
    send(pack6(-32768, 32767, 128, -128, 608, 607));
    wait_ov(k);
    checks++; if (k != 6) $display("FAIL sat_latency got %0d want 6", k); else passed++;
    checks++; if (y !== pack6(0, 256, 160, 96, 235, 235))
      $display("FAIL sat_y got %h want %h", y, pack6(0, 256, 160, 96, 235, 235)); else passed++;
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
  endtask

  task automatic test_hold;
    int k;
    int bad_y;
    int bad_ir;
    int bad_ov;
    logic [95:0] exp_y;
    exp_y  = pack6(128, 192, 64, 224, 240, 256);
    bad_y  = 0;
    bad_ir = 0;
    bad_ov = 0;
    send(pack6(0, 256, -256, 512, 768, 1280));
    wait_ov(k);
    checks++; if (k != 6) $display("FAIL hold_latency got %0d want 6", k); else passed++;
    for (int i = 0; i < 10; i++) begin
      x        = {$urandom(), $urandom(), $urandom()};
      in_valid = ~in_valid;
      @(negedge clk);
      if (y !== exp_y) bad_y++;
      if (in_ready !== 1'b0) bad_ir++;
      if (out_valid !== 1'b1) bad_ov++;
    end
    in_valid = 1'b0;
    checks++; if (bad_y != 0) $display("FAIL hold_y_stable got %0d bad cycles want 0", bad_y); else passed++;
    checks++; if (bad_ir != 0) $display("FAIL hold_in_ready got %0d bad cycles want 0", bad_ir); else passed++;
    checks++; if (bad_ov != 0) $display("FAIL hold_out_valid got %0d bad cycles want 0", bad_ov); else passed++;
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
    checks++; if (out_valid !== 1'b0) $display("FAIL hold_release_ov got %0b want 0", out_valid); else passed++;
    checks++; if (in_ready !== 1'b1) $display("FAIL hold_release_ir got %0b want 1", in_ready); else passed++;
  endtask

  task automatic test_back_to_back;
    logic [95:0] vin  [3];
    logic [95:0] vexp [3];
    int p;
    int cyc;
    int last;
    vin[0]  = pack6(0, 256, -256, 512, 768, 1280);
    vexp[0] = pack6(128, 192, 64, 224, 240, 256);
    vin[1]  = pack6(-32768, 32767, 128, -128, 608, 607);
    vexp[1] = pack6(0, 256, 160, 96, 235, 235);
    vin[2]  = pack6(-256, -256, -256, -256, -256, -256);
    vexp[2] = pack6(64, 64, 64, 64, 64, 64);
    p    = 0;
    last = 0;
    x         = vin[0];
    in_valid  = 1'b1;
    out_ready = 1'b1;
    for (cyc = 1; cyc <= 34; cyc++) begin
      @(negedge clk);
      if (out_valid === 1'b1) begin
        if (p < 3) begin
          checks++; if (y !== vexp[p]) $display("FAIL b2b_y%0d got %h want %h", p, y, vexp[p]); else passed++;
          if (p == 0) begin
            checks++; if (cyc != 7) $display("FAIL b2b_first got cycle %0d want 7", cyc); else passed++;
          end else begin
            checks++; if (cyc - last != 8) $display("FAIL b2b_spacing%0d got %0d want 8", p, cyc - last); else passed++;
          end
        end
        last = cyc;
        p++;
        if (p < 3) x = vin[p];
        else in_valid = 1'b0;
      end
    end
    in_valid  = 1'b0;
    out_ready = 1'b0;
    checks++; if (p != 3) $display("FAIL b2b_pulses got %0d want 3", p); else passed++;
  endtask

  task automatic test_reset_mid_run;
    int k;
    send(pack6(0, 256, -256, 512, 768, 1280));
    repeat (3) @(negedge clk);
    reset = 1'b0;
    #1;
    checks++; if (out_valid !== 1'b0) $display("FAIL midrst_out_valid got %0b want 0", out_valid); else passed++;
    checks++; if (y !== 96'd0) $display("FAIL midrst_y got %h want 0", y); else passed++;
    checks++; if (in_ready !== 1'b1) $display("FAIL midrst_in_ready got %0b want 1", in_ready); else passed++;
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    send(pack6(256, 256, 256, 256, 256, 256));
    wait_ov(k);
    checks++; if (k != 6) $display("FAIL midrst_latency got %0d want 6", k); else passed++;
    checks++; if (y !== pack6(192, 192, 192, 192, 192, 192))
      $display("FAIL midrst_y_after got %h want %h", y, pack6(192, 192, 192, 192, 192, 192)); else passed++;
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
  endtask

  initial begin
    checks    = 0;
    passed    = 0;
    reset     = 1'b0;
    in_valid  = 1'b0;
    out_ready = 1'b0;
    x         = '0;
    repeat (2) @(negedge clk);
    test_reset;
    test_idle_quiet;
    test_basic;
    test_saturation;
    test_hold;
    test_back_to_back;
    test_reset_mid_run;
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
